btn_reader: RTL and testbench
=============================

Name: btn_reader

Overview:
- Input-side counterpart of the LED output path: samples NBTN raw push-button/switch pins and synchronises and debounces them.
- Produces stable levels, one-cycle edge pulses, per-button wrapping press counters and a maskable, sticky interrupt.
- Sits in the io group beside the LED driver and feeds the CPU's io register block.

Parameters:
NBTN, 3, number of button inputs
TICK_DIV, 50000, mclk cycles per debounce sample tick (>=2)
DB_CNT, 4, consecutive differing samples required to accept a new level (>=2)
CNT_W, 8, width of each press counter

Ports:
mclk  in  1  system clock
mrst  in  1  asynchronous reset, active-high
btn_in  in  NBTN  raw button pins, asynchronous to mclk
irq_en  in  NBTN  per-button interrupt enable
irq_clr  in  NBTN  per-button pending clear, 1-cycle pulse
btn_state  out  NBTN  debounced level
btn_rise  out  NBTN  1-cycle pulse on debounced 0->1
btn_fall  out  NBTN  1-cycle pulse on debounced 1->0
press_cnt  out  NBTN*CNT_W  press counters, button i at [i*CNT_W +: CNT_W]
irq_pend  out  NBTN  sticky pending bits
irq  out  1  OR of irq_pend

Behaviour:
- Reset (mrst=1, async) clears the following to 0: synchroniser flops, prescaler, debounce counters, btn_state, btn_rise, btn_fall, press_cnt, irq_pend and irq.
- Synchroniser: 2 flops per bit, giving btn_sync. Nothing else samples btn_in.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick=1 for exactly one cycle when prescaler==TICK_DIV-1.
- Per button, on tick:
  - btn_sync==btn_state: debounce counter cleared.
  - btn_sync!=btn_state and counter<DB_CNT-1: counter increments.
  - btn_sync!=btn_state and counter==DB_CNT-1: btn_state toggles at this edge and the counter clears.
- No state change happens on non-tick cycles.
- Edge pulses: btn_rise/btn_fall are registered. Each is high for exactly the one cycle in which btn_state first shows its new value, and low otherwise.
- press_cnt[i]:
  - Increments by 1 in the cycle btn_rise[i]=1 is registered, so it shows the new value one cycle after the rise pulse.
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
  - Falls do not count.
- irq_pend[i]:
  - Set in the cycle after btn_rise[i]=1 if irq_en[i]=1 in the rise cycle.
  - Cleared by irq_clr[i]=1.
  - If a set and a clear land on the same edge, set wins.
  - Deasserting irq_en does not clear a pending bit.
- irq: registered OR of the irq_pend next-state, so irq and irq_pend change on the same edge.
- Latency from a clean btn_in change to btn_state change:
  - minimum 2 + (DB_CNT-1)*TICK_DIV + 1 cycles;
  - maximum 2 + DB_CNT*TICK_DIV cycles.
- A glitch lasting fewer than DB_CNT consecutive ticks never changes btn_state and produces no pulse.
- Buttons are fully independent. Simultaneous events on several buttons are each handled in the same cycle.
- A reset asserted mid-debounce discards partial counts. After release, an input that is already 1 needs the full debounce before btn_state=1, and then produces a rise pulse and a count.

Test Plan (TICK_DIV=4, DB_CNT=3, CNT_W=2, NBTN=3):
- Reset, then btn_in[0]=1 held. Required:
  - btn_state[0]=1 within 2+12 cycles, and not before 2+8+1 cycles;
  - btn_rise[0] high exactly 1 cycle;
  - press_cnt[0]=1 on the next cycle.
  - Release then gives btn_fall[0] as a single pulse, with press_cnt unchanged.
- btn_in[1] pulsed high for 6 cycles (<3 ticks), repeated 5 times with 10-cycle gaps -> btn_state[1] stays 0, no rise/fall pulses, press_cnt[1]=0.
- Four full debounced presses on button 2 -> press_cnt[2] reads 1,2,3,0 (wrap).
- irq_en=3'b001, press buttons 0 and 1 -> irq_pend=3'b001 and irq=1. Then irq_clr[0] pulsed on the same edge a new rise sets it -> irq_pend[0] stays 1. A later lone irq_clr[0] -> irq_pend=0, irq=0.
- Hold btn_in[0]=1 and assert mrst after 2 ticks of debounce -> all outputs 0 immediately (async). Release mrst -> full debounce latency again, then one rise pulse and press_cnt[0]=1.
- Buttons 0 and 2 pressed in the same cycle -> btn_rise=3'b101 in a single cycle, and both counters increment together.

Source files
------------

// File: rtl/btn_reader.sv
// Push-button input path: 2-flop sync, tick-paced debounce, edge pulses,
// wrapping press counters and a sticky maskable interrupt per button.

module btn_lane #(
    parameter int DB_CNT = 4,
    parameter int CNT_W  = 8
) (
    input  logic             mclk,
    input  logic             mrst,
    input  logic             tick,
    input  logic             sync_bit,
    input  logic             en,
    input  logic             clr,
    output logic             state,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cnt,
    output logic             pend,
    output logic             pend_nxt
);
    localparam int DW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

    logic [DW-1:0] db_cnt;
    logic          flip;

    // Level accepted on the tick that sees the DB_CNT-th consecutive mismatch
    assign flip     = tick && (sync_bit != state) && (db_cnt == DW'(DB_CNT - 1));
    assign pend_nxt = (rise & en) | (pend & ~clr);

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            db_cnt <= '0;
            state  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            cnt    <= '0;
            pend   <= 1'b0;
        end else begin
            rise <= flip & ~state;
            fall <= flip & state;
            if (tick) begin
                if (sync_bit == state || flip)
                    db_cnt <= '0;
                else
                    db_cnt <= db_cnt + DW'(1);
            end
            if (flip)
                state <= ~state;
            if (rise)
                cnt <= cnt + CNT_W'(1);
            pend <= pend_nxt;
        end
    end
endmodule

module btn_reader #(
    parameter int NBTN     = 3,
    parameter int TICK_DIV = 50000,
    parameter int DB_CNT   = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  mclk,
    input  logic                  mrst,
    input  logic [NBTN-1:0]       btn_in,
    input  logic [NBTN-1:0]       irq_en,
    input  logic [NBTN-1:0]       irq_clr,
    output logic [NBTN-1:0]       btn_state,
    output logic [NBTN-1:0]       btn_rise,
    output logic [NBTN-1:0]       btn_fall,
    output logic [NBTN*CNT_W-1:0] press_cnt,
    output logic [NBTN-1:0]       irq_pend,
    output logic                  irq
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [NBTN-1:0]            sync_q1, btn_sync;
    logic [PW-1:0]              presc;
    logic                       tick;
    logic [NBTN-1:0]            pend_nxt;
    logic [NBTN-1:0][CNT_W-1:0] cnt_q;

    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign press_cnt = cnt_q;

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            sync_q1  <= '0;
            btn_sync <= '0;
            presc    <= '0;
            irq      <= 1'b0;
        end else begin
            sync_q1  <= btn_in;
            btn_sync <= sync_q1;
            presc    <= tick ? '0 : presc + PW'(1);
            // Built from next-state so irq moves on the same edge as irq_pend
            irq      <= |pend_nxt;
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_lane
        btn_lane #(
            .DB_CNT (DB_CNT),
            .CNT_W  (CNT_W)
        ) u_lane (
            .mclk     (mclk),
            .mrst     (mrst),
            .tick     (tick),
            .sync_bit (btn_sync[g]),
            .en       (irq_en[g]),
            .clr      (irq_clr[g]),
            .state    (btn_state[g]),
            .rise     (btn_rise[g]),
            .fall     (btn_fall[g]),
            .cnt      (cnt_q[g]),
            .pend     (irq_pend[g]),
            .pend_nxt (pend_nxt[g])
        );
    end
endmodule

// File: tb/tb_btn_reader.sv
// Directed bench for btn_reader at TICK_DIV=4, DB_CNT=3, CNT_W=2, NBTN=3.
// Debounce latency window after a clean change is 11..14 cycles.

module tb_btn_reader;
    logic       mclk = 1'b0;
    logic       mrst = 1'b1;
    logic [2:0] btn_in  = '0;
    logic [2:0] irq_en  = '0;
    logic [2:0] irq_clr = '0;
    logic [2:0] btn_state, btn_rise, btn_fall, irq_pend;
    logic [5:0] press_cnt;
    logic       irq;

    int checks = 0;
    int errors = 0;

    btn_reader #(.NBTN(3), .TICK_DIV(4), .DB_CNT(3), .CNT_W(2)) dut (
        .mclk      (mclk),
        .mrst      (mrst),
        .btn_in    (btn_in),
        .irq_en    (irq_en),
        .irq_clr   (irq_clr),
        .btn_state (btn_state),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .press_cnt (press_cnt),
        .irq_pend  (irq_pend),
        .irq       (irq)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [2:0] btn;
        logic [2:0] en;
        logic [2:0] st;
        logic [5:0] cnt;
        logic [2:0] pend;
        logic       irq;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_state(input int i, input logic v, input int budget, output int n);
        n = 0;
        while (btn_state[i] !== v && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  bad;
        logic [31:0] all_out;

        // button 2 press/release x4 (count wraps), then interrupt behaviour
        tbl[0]  = '{3'b100, 3'b000, 3'b100, 6'b01_00_01, 3'b000, 1'b0};
        tbl[1]  = '{3'b000, 3'b000, 3'b000, 6'b01_00_01, 3'b000, 1'b0};
        tbl[2]  = '{3'b100, 3'b000, 3'b100, 6'b10_00_01, 3'b000, 1'b0};
        tbl[3]  = '{3'b000, 3'b000, 3'b000, 6'b10_00_01, 3'b000, 1'b0};
        tbl[4]  = '{3'b100, 3'b000, 3'b100, 6'b11_00_01, 3'b000, 1'b0};
        tbl[5]  = '{3'b000, 3'b000, 3'b000, 6'b11_00_01, 3'b000, 1'b0};
        tbl[6]  = '{3'b100, 3'b000, 3'b100, 6'b00_00_01, 3'b000, 1'b0};
        tbl[7]  = '{3'b000, 3'b000, 3'b000, 6'b00_00_01, 3'b000, 1'b0};
        tbl[8]  = '{3'b011, 3'b001, 3'b011, 6'b00_01_10, 3'b001, 1'b1};
        tbl[9]  = '{3'b000, 3'b001, 3'b000, 6'b00_01_10, 3'b001, 1'b1};
        tbl[10] = '{3'b000, 3'b000, 3'b000, 6'b00_01_10, 3'b001, 1'b1};

        // reset state
        #2;
        all_out = {14'd0, btn_state, btn_rise, btn_fall, press_cnt, irq_pend, irq};
        chk("reset_outputs", all_out, 32'd0);
        step();
        step();

        // button 0 clean press: latency window, single rise, count
        mrst = 1'b0;
        btn_in = 3'b001;
        wait_state(0, 1'b1, 30, n);
        chk("b0_latency_min", 32'(n >= 11), 32'd1);
        chk("b0_latency_max", 32'(n <= 14), 32'd1);
        chk("b0_rise", 32'(btn_rise), 32'b001);
        chk("b0_cnt_before", 32'(press_cnt), 32'd0);
        step();
        chk("b0_rise_gone", 32'(btn_rise), 32'b000);
        chk("b0_cnt", 32'(press_cnt), 32'b00_00_01);

        btn_in = 3'b000;
        wait_state(0, 1'b0, 30, n);
        chk("b0_fall_timeout", 32'(n < 30), 32'd1);
        chk("b0_fall", 32'(btn_fall), 32'b001);
        step();
        chk("b0_fall_gone", 32'(btn_fall), 32'b000);
        chk("b0_cnt_after_fall", 32'(press_cnt), 32'b00_00_01);

        // glitches on button 1 shorter than the debounce window
        bad = 1'b0;
        for (int r = 0; r < 5; r++) begin
            btn_in[1] = 1'b1;
            for (int c = 0; c < 6; c++) begin
                step();
                bad |= btn_state[1] | btn_rise[1] | btn_fall[1];
            end
            btn_in[1] = 1'b0;
            for (int c = 0; c < 10; c++) begin
                step();
                bad |= btn_state[1] | btn_rise[1] | btn_fall[1];
            end
        end
        chk("b1_glitch_quiet", 32'(bad), 32'd0);
        chk("b1_glitch_cnt", 32'(press_cnt[3:2]), 32'd0);

        // table of settled levels
        for (int k = 0; k < 11; k++) begin
            btn_in = tbl[k].btn;
            irq_en = tbl[k].en;
            repeat (20) step();
            chk($sformatf("tbl%0d_state", k), 32'(btn_state), 32'(tbl[k].st));
            chk($sformatf("tbl%0d_cnt", k), 32'(press_cnt), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d_pend", k), 32'(irq_pend), 32'(tbl[k].pend));
            chk($sformatf("tbl%0d_irq", k), 32'(irq), 32'(tbl[k].irq));
        end

        // clear landing on the same edge as a new set: set wins
        irq_en = 3'b001;
        btn_in = 3'b001;
        wait_state(0, 1'b1, 30, n);
        chk("irq_rise", 32'(btn_rise), 32'b001);
        irq_clr = 3'b001;
        step();
        irq_clr = 3'b000;
        chk("irq_setwins_pend", 32'(irq_pend), 32'b001);
        chk("irq_setwins_irq", 32'(irq), 32'd1);
        chk("irq_cnt", 32'(press_cnt), 32'b00_01_11);
        step();
        irq_clr = 3'b001;
        step();
        irq_clr = 3'b000;
        chk("irq_clr_pend", 32'(irq_pend), 32'b000);
        chk("irq_clr_irq", 32'(irq), 32'd0);
        btn_in = 3'b000;
        irq_en = 3'b000;
        wait_state(0, 1'b0, 30, n);
        chk("irq_release", 32'(btn_state), 32'b000);

        // reset in the middle of a debounce
        btn_in = 3'b001;
        repeat (10) step();
        chk("mid_no_early_accept", 32'(btn_state), 32'b000);
        #2;
        mrst = 1'b1;
        #1;
        all_out = {14'd0, btn_state, btn_rise, btn_fall, press_cnt, irq_pend, irq};
        chk("mid_reset_async", all_out, 32'd0);
        step();
        step();
        mrst = 1'b0;
        wait_state(0, 1'b1, 30, n);
        chk("mid_latency_min", 32'(n >= 11), 32'd1);
        chk("mid_latency_max", 32'(n <= 14), 32'd1);
        chk("mid_rise", 32'(btn_rise), 32'b001);
        step();
        chk("mid_rise_gone", 32'(btn_rise), 32'b000);
        chk("mid_cnt", 32'(press_cnt), 32'b00_00_01);

        // simultaneous press on buttons 0 and 2
        btn_in = 3'b000;
        wait_state(0, 1'b0, 30, n);
        btn_in = 3'b101;
        n = 0;
        while (btn_rise === 3'b000 && n < 30) begin
            step();
            n++;
        end
        chk("sim_rise", 32'(btn_rise), 32'b101);
        chk("sim_state", 32'(btn_state), 32'b101);
        step();
        chk("sim_rise_gone", 32'(btn_rise), 32'b000);
        chk("sim_cnt", 32'(press_cnt), 32'b01_00_10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
